bpm_setter: RTL and testbench

Upstream BPM source for the seven-segment BPM display chain. Turns two raw push-buttons (up/down) into a clamped 14-bit BPM value. Each button is synchronised and debounced, then drives a step / hold / auto-repeat control FSM; pressing both buttons restores the default tempo. The output drives the display chain's BPM count input and the beat-period generator.

---
 rtl/bpm_pkg.sv | 38 +++
 rtl/bpm_debounce.sv | 74 +++++++
 rtl/bpm_setter.sv | 233 +++++++++++++++++++++++
 tb/tb_bpm_setter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_pkg.sv
// -----------------------------------------------------------------------------
// bpm_pkg
// Shared definitions for the BPM setter:
//   BPM_W        width of the BPM value bus (up to 9999 fits in 14 bits)
//   bpm_state_e  control FSM states (IDLE / PRESS / REPEAT / BOTH)
//   bpm_req_e    registered step request handed from the FSM to the BPM register
//   clog2()      counter sizing helper, never returns less than 1
// -----------------------------------------------------------------------------
package bpm_pkg;

    localparam int BPM_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_BOTH   = 2'd3
    } bpm_state_e;

    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_UP      = 2'd1,
        REQ_DOWN    = 2'd2,
        REQ_DEFAULT = 2'd3
    } bpm_req_e;

    // Bits needed to hold the values 0 .. value-1. Clamped to at least 1 so a
    // counter that only ever holds 0 still has a legal declaration.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bpm_debounce.sv
// -----------------------------------------------------------------------------
// bpm_debounce
// Two-flop synchroniser followed by a ms-tick based stability counter for one
// raw push-button.
//   i_clk      system clock
//   i_reset    asynchronous active-low reset
//   i_ms_tick  one-cycle pulse per millisecond
//   i_raw      raw button level, asynchronous to i_clk
//   o_level    debounced level
//   o_rise     one-cycle pulse, coincident with o_level going 0 -> 1
// -----------------------------------------------------------------------------
module bpm_debounce
    import bpm_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ms_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int               CNT_W    = clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            // Any sample agreeing with the accepted level restarts the count,
            // so only an unbroken run of disagreeing ticks can flip it.
            cnt_d = '0;
        end else if (i_ms_tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/bpm_setter.sv
// -----------------------------------------------------------------------------
// bpm_setter
// Turns raw up/down push-buttons into a clamped BPM value for the display
// chain and the beat-period generator. Buttons are synchronised and debounced,
// then a step / hold / auto-repeat FSM issues step requests. Pressing both
// buttons restores BPM_DEFAULT.
//   i_clk          system clock
//   i_reset        asynchronous active-low reset
//   i_btn_up       raw up button, active-high
//   i_btn_down     raw down button, active-high
//   o_bpm_count    current BPM (registered)
//   o_bpm_changed  one-cycle pulse when o_bpm_count takes a new value
//   o_at_limit     high while o_bpm_count sits on BPM_MIN or BPM_MAX
// -----------------------------------------------------------------------------
module bpm_setter
    import bpm_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int BPM_MIN     = 30,
    parameter int BPM_MAX     = 300,
    parameter int BPM_DEFAULT = 120,
    parameter int STEP        = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    output logic [BPM_W-1:0] o_bpm_count,
    output logic             o_bpm_changed,
    output logic             o_at_limit
);

    // ---------------------------------------------------------------- ms tick
    localparam int DIV     = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
    localparam int PRESC_W = clog2(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               ms_tick;

    assign ms_tick = (presc_q == PRESC_LAST);
    assign presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------- button debounce
    // Index 0 is the up button, index 1 the down button.
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;

    assign btn_raw = {i_btn_down, i_btn_up};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        bpm_debounce #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_debounce (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_ms_tick (ms_tick),
            .i_raw     (btn_raw[gi]),
            .o_level   (btn_level[gi]),
            .o_rise    (btn_rise[gi])
        );
    end

    logic up_level;
    logic dn_level;
    logic up_rise;
    logic dn_rise;

    assign up_level = btn_level[0];
    assign dn_level = btn_level[1];
    assign up_rise  = btn_rise[0];
    assign dn_rise  = btn_rise[1];

    // ------------------------------------------------------------ control FSM
    localparam int HOLD_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int HOLD_W   = clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_MS - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_MS - 1);

    bpm_state_e        state_q;
    bpm_state_e        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              held_up_q;   // which button owns PRESS/REPEAT
    logic              held_up_d;
    bpm_req_e          req_q;
    bpm_req_e          req_d;

    logic              held_level;
    logic              other_rise;
    bpm_req_e          held_req;
    logic [HOLD_W-1:0] period_last;

    assign held_level  = held_up_q ? up_level : dn_level;
    assign other_rise  = held_up_q ? dn_rise : up_rise;
    assign held_req    = held_up_q ? REQ_UP : REQ_DOWN;
    // PRESS and REPEAT share one counter; only the terminal count differs.
    assign period_last = (state_q == ST_PRESS) ? HOLD_LAST : REPEAT_LAST;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        held_up_d = held_up_q;
        req_d     = REQ_NONE;
        case (state_q)
            ST_IDLE: begin
                if (up_level && dn_level) begin
                    state_d = ST_BOTH;
                    req_d   = REQ_DEFAULT;
                end else if (up_rise) begin
                    state_d   = ST_PRESS;
                    held_up_d = 1'b1;
                    hold_d    = '0;
                    req_d     = REQ_UP;
                end else if (dn_rise) begin
                    state_d   = ST_PRESS;
                    held_up_d = 1'b0;
                    hold_d    = '0;
                    req_d     = REQ_DOWN;
                end
            end
            ST_PRESS, ST_REPEAT: begin
                // The second button arriving wins over everything else and
                // its edge never produces a step of its own.
                if (other_rise) begin
                    state_d = ST_BOTH;
                    req_d   = REQ_DEFAULT;
                end else if (!held_level) begin
                    state_d = ST_IDLE;
                end else if (ms_tick) begin
                    if (hold_q == period_last) begin
                        state_d = ST_REPEAT;
                        hold_d  = '0;
                        req_d   = held_req;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_BOTH: begin
                if (!up_level && !dn_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            held_up_q <= 1'b0;
            req_q     <= REQ_NONE;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            held_up_q <= held_up_d;
            req_q     <= req_d;
        end
    end

    // ----------------------------------------------------------- BPM register
    localparam logic [BPM_W:0]   STEP_X = (BPM_W + 1)'(STEP);
    localparam logic [BPM_W:0]   MIN_X  = (BPM_W + 1)'(BPM_MIN);
    localparam logic [BPM_W:0]   MAX_X  = (BPM_W + 1)'(BPM_MAX);
    localparam logic [BPM_W-1:0] MIN_V  = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] MAX_V  = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] DEF_V  = BPM_W'(BPM_DEFAULT);

    logic [BPM_W-1:0] bpm_q;
    logic [BPM_W-1:0] bpm_d;
    logic             changed_q;
    logic             changed_d;
    logic             at_limit_q;
    logic             at_limit_d;
    logic [BPM_W:0]   up_sum;
    logic [BPM_W:0]   dn_diff;
    logic [BPM_W-1:0] up_next;
    logic [BPM_W-1:0] dn_next;

    always_comb begin
        // One spare bit catches both overflow above the 14-bit range and the
        // borrow of a step below zero before clamping.
        up_sum  = {1'b0, bpm_q} + STEP_X;
        dn_diff = {1'b0, bpm_q} - STEP_X;
        up_next = (up_sum > MAX_X) ? MAX_V : up_sum[BPM_W-1:0];
        dn_next = (dn_diff[BPM_W] || (dn_diff < MIN_X)) ? MIN_V : dn_diff[BPM_W-1:0];

        bpm_d = bpm_q;
        case (req_q)
            REQ_UP:      bpm_d = up_next;
            REQ_DOWN:    bpm_d = dn_next;
            REQ_DEFAULT: bpm_d = DEF_V;
            default:     bpm_d = bpm_q;
        endcase

        changed_d  = (bpm_d != bpm_q);
        at_limit_d = (bpm_d == MIN_V) || (bpm_d == MAX_V);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bpm_q      <= DEF_V;
            changed_q  <= 1'b0;
            at_limit_q <= (BPM_DEFAULT == BPM_MIN) || (BPM_DEFAULT == BPM_MAX);
        end else begin
            bpm_q      <= bpm_d;
            changed_q  <= changed_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign o_bpm_count   = bpm_q;
    assign o_bpm_changed = changed_q;
    assign o_at_limit    = at_limit_q;

endmodule

// File: tb/tb_bpm_setter.sv
// -----------------------------------------------------------------------------
// tb_bpm_setter
// Self-checking bench for bpm_setter with a 1 ms tick per clock. A behavioural
// model (button history windows plus an arithmetic step schedule measured from
// the press cycle) predicts the outputs after every clock edge; table rows and
// hand sequences add fixed expectations for the documented corner cases.
// -----------------------------------------------------------------------------
module tb_bpm_setter;

    localparam int DB   = 2;
    localparam int HOLD = 5;
    localparam int REP  = 2;
    localparam int BMIN = 30;
    localparam int BMAX = 300;
    localparam int BDEF = 120;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic [13:0] bpm;
    logic        changed;
    logic        at_limit;

    always #5 clk = ~clk;

    bpm_setter #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (DB),
        .HOLD_MS     (HOLD),
        .REPEAT_MS   (REP),
        .BPM_MIN     (BMIN),
        .BPM_MAX     (BMAX),
        .BPM_DEFAULT (BDEF),
        .STEP        (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_btn_up      (btn_up),
        .i_btn_down    (btn_dn),
        .o_bpm_count   (bpm),
        .o_bpm_changed (changed),
        .o_at_limit    (at_limit)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    // ------------------------------------------------------------ model state
    int m_bpm, m_chg, m_lim;
    int m_mode;     // 0 idle, 1 up held, 2 down held, 3 both
    int m_pend;     // action decided last edge: 0 none, 1 up, 2 down, 3 default
    int m_press;    // cycle at which the current press was accepted
    int m_cyc = 0;
    bit m_lvl [2];
    bit m_rise [2];
    bit m_hist [2][8];  // m_hist[b][k] = raw level sampled k edges ago

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", name, m_cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bpm  = BDEF;
        m_chg  = 0;
        m_lim  = 0;
        m_mode = 0;
        m_pend = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b]  = 1'b0;
            m_rise[b] = 1'b0;
            for (int k = 0; k < 8; k++) m_hist[b][k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ru, input bit rd);
        int  nv;
        int  held;
        int  d;
        bit  flip;
        bit  raw [2];
        raw[0] = ru;
        raw[1] = rd;
        // Outputs after this edge reflect the action chosen one edge earlier.
        nv = m_bpm;
        case (m_pend)
            1: nv = (m_bpm + 1 > BMAX) ? BMAX : m_bpm + 1;
            2: nv = (m_bpm - 1 < BMIN) ? BMIN : m_bpm - 1;
            3: nv = BDEF;
            default: nv = m_bpm;
        endcase
        m_chg  = (nv != m_bpm) ? 1 : 0;
        m_bpm  = nv;
        m_lim  = (m_bpm == BMIN || m_bpm == BMAX) ? 1 : 0;
        m_pend = 0;
        // Decision from the debounced levels as they stood before this edge.
        case (m_mode)
            0: begin
                if (m_lvl[0] && m_lvl[1]) begin
                    m_mode = 3; m_pend = 3;
                end else if (m_rise[0]) begin
                    m_mode = 1; m_pend = 1; m_press = m_cyc;
                end else if (m_rise[1]) begin
                    m_mode = 2; m_pend = 2; m_press = m_cyc;
                end
            end
            1, 2: begin
                held = m_mode - 1;
                if (m_rise[1 - held]) begin
                    m_mode = 3; m_pend = 3;
                end else if (!m_lvl[held]) begin
                    m_mode = 0;
                end else begin
                    d = m_cyc - m_press;
                    if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) m_pend = m_mode;
                end
            end
            default: begin
                if (!m_lvl[0] && !m_lvl[1]) m_mode = 0;
            end
        endcase
        // Debounced level flips once the DB samples seen through the two-flop
        // synchroniser (raw from 2..DB+1 edges ago) all disagree with it.
        for (int b = 0; b < 2; b++) begin
            for (int k = 7; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = raw[b];
            flip = 1'b1;
            for (int j = 0; j < DB; j++) if (m_hist[b][2+j] == m_lvl[b]) flip = 1'b0;
            m_rise[b] = flip && !m_lvl[b];
            if (flip) m_lvl[b] = !m_lvl[b];
        end
        m_cyc++;
    endtask

    // One clock: entered at a negedge, drives inputs, checks after the posedge.
    task automatic cycle(input bit ru, input bit rd);
        btn_up = ru;
        btn_dn = rd;
        @(posedge clk);
        model_step(ru, rd);
        #1;
        check("bpm", int'(bpm), m_bpm);
        check("changed", int'(changed), m_chg);
        check("at_limit", int'(at_limit), m_lim);
        if (changed) pulses++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic short_press(input bit up);
        repeat (3) cycle(up, !up);
        repeat (8) cycle(1'b0, 1'b0);
    endtask

    task automatic drive_to(input int target);
        int guard;
        int k;
        bit up;
        guard = 0;
        while (m_bpm != target && guard < 80) begin
            guard++;
            up = (target > m_bpm);
            if (target - m_bpm > 5 || m_bpm - target > 5) begin
                k = 0;
                while ((target - m_bpm > 5 || m_bpm - target > 5) && k < 1000) begin
                    cycle(up, !up);
                    k++;
                end
                repeat (8) cycle(1'b0, 1'b0);
            end else begin
                short_press(up);
            end
        end
        check($sformatf("drive_to_%0d", target), int'(bpm), target);
        $display("drive_to %0d: bpm=%0d", target, bpm);
    endtask

    typedef struct {
        bit rst;
        bit up;
        bit dn;
        int n;
        int exp_bpm;
        int exp_pulses;
    } vec_t;

    vec_t vt [8];

    initial begin
        int k;
        int r;
        int len;

        vt[0] = '{1'b1, 1'b1, 1'b0, 15, 124, 4};  // continuous hold: press, hold, repeats
        vt[1] = '{1'b0, 1'b0, 1'b0, 10, 126, 2};  // release: last two repeats land
        vt[2] = '{1'b1, 1'b1, 1'b0,  1, 120, 0};  // single-cycle glitch
        vt[3] = '{1'b0, 1'b0, 1'b0,  8, 120, 0};
        vt[4] = '{1'b0, 1'b1, 1'b0,  3, 120, 0};  // 3-cycle press
        vt[5] = '{1'b0, 1'b0, 1'b0,  8, 121, 1};
        vt[6] = '{1'b0, 1'b0, 1'b1,  3, 121, 0};  // 3-cycle down press
        vt[7] = '{1'b0, 1'b0, 1'b0,  8, 120, 1};

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_bpm", int'(bpm), BDEF);
        check("reset_changed", int'(changed), 0);
        check("reset_at_limit", int'(at_limit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_bpm", int'(bpm), BDEF);
        @(negedge clk);

        // ---------------------------------------------------------- table rows
        for (int i = 0; i < 8; i++) begin
            if (vt[i].rst) apply_reset();
            pulses = 0;
            for (int c = 0; c < vt[i].n; c++) cycle(vt[i].up, vt[i].dn);
            check($sformatf("row%0d_bpm", i), int'(bpm), vt[i].exp_bpm);
            check($sformatf("row%0d_pulses", i), pulses, vt[i].exp_pulses);
            $display("row %0d: up=%0b dn=%0b n=%0d bpm=%0d pulses=%0d", i, vt[i].up, vt[i].dn,
                     vt[i].n, bpm, pulses);
        end

        // ------------------------------------------------ upper and lower clamp
        drive_to(299);
        pulses = 0;
        repeat (20) cycle(1'b1, 1'b0);
        check("clamp_hi_bpm", int'(bpm), 300);
        check("clamp_hi_pulses", pulses, 1);
        check("clamp_hi_at_limit", int'(at_limit), 1);
        repeat (8) cycle(1'b0, 1'b0);
        $display("clamp_hi: bpm=%0d pulses=%0d at_limit=%0b", bpm, pulses, at_limit);
        drive_to(31);
        pulses = 0;
        repeat (20) cycle(1'b0, 1'b1);
        check("clamp_lo_bpm", int'(bpm), 30);
        check("clamp_lo_pulses", pulses, 1);
        check("clamp_lo_at_limit", int'(at_limit), 1);
        repeat (8) cycle(1'b0, 1'b0);
        $display("clamp_lo: bpm=%0d pulses=%0d at_limit=%0b", bpm, pulses, at_limit);

        // ------------------------------------------------------- both buttons
        drive_to(150);
        repeat (10) cycle(1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b1);
        check("both_bpm", int'(bpm), BDEF);
        check("both_at_limit", int'(at_limit), 0);
        pulses = 0;
        repeat (12) cycle(1'b0, 1'b1);
        check("both_release_up_bpm", int'(bpm), BDEF);
        check("both_release_up_pulses", pulses, 0);
        repeat (8) cycle(1'b0, 1'b0);
        short_press(1'b1);
        check("after_both_press", int'(bpm), 121);
        $display("both: bpm=%0d", bpm);

        // --------------------------------------------------- reset mid-repeat
        drive_to(130);
        k = 0;
        while (m_bpm != 140 && k < 300) begin
            cycle(1'b1, 1'b0);
            k++;
        end
        check("repeat_reach_140", int'(bpm), 140);
        rst_n = 1'b0;
        #1;
        check("async_reset_bpm", int'(bpm), BDEF);
        check("async_reset_changed", int'(changed), 0);
        check("async_reset_at_limit", int'(at_limit), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0);
        check("held_after_reset_wait", int'(bpm), BDEF);
        cycle(1'b1, 1'b0);
        check("held_after_reset_step", int'(bpm), 121);
        repeat (8) cycle(1'b0, 1'b0);
        $display("reset_mid_repeat: bpm=%0d", bpm);

        // ------------------------------------------------ randomized segments
        for (int s = 0; s < 60; s++) begin
            r   = $urandom_range(0, 3);
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) cycle(r[0], r[1]);
            $display("random seg %0d: up=%0b dn=%0b len=%0d bpm=%0d", s, r[0], r[1], len, bpm);
        end
        repeat (10) cycle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
